// File: rtl/irq_arb_pkg.sv
// Shared types and helpers for the vectored-interrupt arbiter.
package irq_arb_pkg;

  localparam int VEC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_e;

  // Width of a device index; at least one bit so NIRQ=1 still has a port.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Rotating-start priority encoder: first set request at or after i_start, wrapping.
module irq_prio_enc
  import irq_arb_pkg::*;
#(
  parameter int NIRQ = 8,
  parameter int IW   = idx_w(NIRQ)
) (
  input  logic [NIRQ-1:0] i_req,
  input  logic [IW-1:0]   i_start,
  output logic            o_hit,
  output logic [IW-1:0]   o_idx
);

  // Scan from the far end back toward i_start so the nearest hit is written last.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int k = NIRQ - 1; k >= 0; k--) begin
      logic [IW-1:0] w_j;
      w_j = IW'((int'(i_start) + k) % NIRQ);
      if (i_req[w_j]) begin
        o_hit = 1'b1;
        o_idx = w_j;
      end
    end
  end

endmodule

// File: rtl/irq_vector_arb.sv
// Vectored-interrupt arbiter: virq/istb/ivec/iack handshake to the CPU, dev_iack to devices.
// Define IRQ_ROUNDROBIN_EN for rotating priority; default build is fixed priority (index 0 wins).
module irq_vector_arb
  import irq_arb_pkg::*;
#(
  parameter int              NIRQ     = 8,
  parameter logic [VEC_W-1:0] VEC_NONE = 16'o0
) (
  input  logic                  i_clk_p,
  input  logic                  i_rst,
  input  logic [NIRQ-1:0]       i_irq_req,
  input  logic [NIRQ*VEC_W-1:0] i_dev_vec,
  output logic [NIRQ-1:0]       o_dev_iack,
  output logic                  o_virq,
  input  logic                  i_istb,
  output logic [VEC_W-1:0]      o_ivec,
  output logic                  o_iack
);

  localparam int IW = idx_w(NIRQ);

  arb_state_e                   r_state, w_state_nxt;
  logic                         r_virq, w_virq_nxt;
  logic                         r_iack, w_iack_nxt;
  logic [VEC_W-1:0]             r_ivec, w_ivec_nxt;
  logic [NIRQ-1:0]              r_dev_iack, w_dev_iack_nxt;
  logic                         r_armed;
  logic [NIRQ-1:0][VEC_W-1:0]   w_vec_tab;
  logic [NIRQ-1:0]              w_onehot;
  logic [IW-1:0]                w_start, w_idx;
  logic                         w_hit;

  assign w_vec_tab = i_dev_vec;

  irq_prio_enc #(.NIRQ(NIRQ), .IW(IW)) u_enc (
    .i_req   (i_irq_req),
    .i_start (w_start),
    .o_hit   (w_hit),
    .o_idx   (w_idx)
  );

`ifdef IRQ_ROUNDROBIN_EN
  logic [IW-1:0] r_last;
  logic          w_grant;

  // Passive VEC_NONE releases must not move the pointer, hence the w_hit term.
  assign w_grant = (r_state == ST_IDLE) && i_istb && w_hit;
  assign w_start = (r_last == IW'(NIRQ - 1)) ? '0 : r_last + IW'(1);

  always_ff @(posedge i_clk_p or posedge i_rst) begin
    if (i_rst)        r_last <= IW'(NIRQ - 1);
    else if (w_grant) r_last <= w_idx;
  end
`else
  assign w_start = '0;
`endif

  always_comb begin
    for (int i = 0; i < NIRQ; i++) w_onehot[i] = (w_idx == IW'(i));
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_virq_nxt     = r_virq;
    w_iack_nxt     = r_iack;
    w_ivec_nxt     = r_ivec;
    w_dev_iack_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        // r_armed holds virq low for the first cycle out of reset.
        w_virq_nxt = r_armed && (|i_irq_req);
        if (i_istb) begin
          w_virq_nxt     = 1'b0;
          w_iack_nxt     = 1'b1;
          w_ivec_nxt     = w_hit ? w_vec_tab[w_idx] : VEC_NONE;
          w_dev_iack_nxt = w_hit ? w_onehot : '0;
          w_state_nxt    = ST_ACK;
        end
      end
      ST_ACK: begin
        w_virq_nxt = 1'b0;
        if (!i_istb) begin
          w_iack_nxt  = 1'b0;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_virq_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_virq_nxt  = 1'b0;
        w_iack_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk_p or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_virq     <= 1'b0;
      r_iack     <= 1'b0;
      r_ivec     <= '0;
      r_dev_iack <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_virq     <= w_virq_nxt;
      r_iack     <= w_iack_nxt;
      r_ivec     <= w_ivec_nxt;
      r_dev_iack <= w_dev_iack_nxt;
      r_armed    <= 1'b1;
    end
  end

  assign o_virq     = r_virq;
  assign o_iack     = r_iack;
  assign o_ivec     = r_ivec;
  assign o_dev_iack = r_dev_iack;

endmodule

// File: tb/tb_irq_vector_arb.sv
// Directed bench for irq_vector_arb; device i's vector is 16'o040 + 8*i.
module tb_irq_vector_arb;
  localparam int NIRQ = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NIRQ-1:0]  irq_req;
  logic [NIRQ*16-1:0] dev_vec;
  logic [NIRQ-1:0]  dev_iack;
  logic             virq;
  logic             istb;
  logic [15:0]      ivec;
  logic             iack;

  int n_chk  = 0;
  int n_fail = 0;

  irq_vector_arb #(.NIRQ(NIRQ), .VEC_NONE(16'o0)) dut (
    .i_clk_p    (clk),
    .i_rst      (rst),
    .i_irq_req  (irq_req),
    .i_dev_vec  (dev_vec),
    .o_dev_iack (dev_iack),
    .o_virq     (virq),
    .i_istb     (istb),
    .o_ivec     (ivec),
    .o_iack     (iack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] exp_oh;
    rst = 1'b1; irq_req = '0; istb = 1'b0;
    for (int i = 0; i < NIRQ; i++) dev_vec[16*i +: 16] = 16'o040 + 16'(8 * i);
    #1;
    chk("rst_iack", iack, 0);
    chk("rst_virq", virq, 0);
    chk("rst_ivec", ivec, 0);
    chk("rst_dev_iack", dev_iack, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: single request on device 2
    irq_req = 8'b0000_0100;
    tick();
    chk("t1_virq", virq, 1);
    istb = 1'b1;
    tick();
    chk("t1_iack", iack, 1);
    chk("t1_ivec", ivec, 16'o060);
    chk("t1_dev_iack", dev_iack, 8'b0000_0100);
    chk("t1_virq_ack", virq, 0);
    tick();
    chk("t1_dev_iack_pulse", dev_iack, 0);
    chk("t1_ivec_frozen", ivec, 16'o060);
    irq_req = '0; istb = 1'b0;
    tick();
    chk("t1_iack_fall", iack, 0);
    tick(); tick();

    // 2: fixed priority 1 over 7; device 7 next strobe
    do_reset();
    irq_req = 8'b1000_0010;
    tick();
    chk("t2_virq", virq, 1);
    istb = 1'b1;
    tick();
    chk("t2_ivec", ivec, 16'o050);
    chk("t2_dev_iack", dev_iack, 8'b0000_0010);
    irq_req = 8'b1000_0000;
    istb = 1'b0;
    tick();
    chk("t2_iack_fall", iack, 0);
    chk("t2_virq_hold", virq, 0);
    tick();
    chk("t2_virq_idle1", virq, 0);
    tick();
    chk("t2_virq_reraise", virq, 1);
    istb = 1'b1;
    tick();
    chk("t2_ivec7", ivec, 16'o130);
    chk("t2_dev_iack7", dev_iack, 8'b1000_0000);
    istb = 1'b0; irq_req = '0;
    tick(); tick();

    // 3: request dropped as istb sampled -> passive release; then simultaneous rise wins
    irq_req = 8'b0000_0001;
    tick();
    chk("t3_virq", virq, 1);
    irq_req = '0; istb = 1'b1;
    tick();
    chk("t3_iack", iack, 1);
    chk("t3_ivec_none", ivec, 0);
    chk("t3_dev_iack", dev_iack, 0);
    istb = 1'b0;
    tick(); tick();
    irq_req = 8'b0010_0000; istb = 1'b1;
    tick();
    chk("t3_same_cycle_ivec", ivec, 16'o110);
    chk("t3_same_cycle_dev", dev_iack, 8'b0010_0000);
    istb = 1'b0; irq_req = '0;
    tick(); tick();

    // 5: request held through the whole handshake
    irq_req = 8'b0000_1000;
    tick();
    chk("t5_virq", virq, 1);
    istb = 1'b1;
    tick();
    chk("t5_virq_ack", virq, 0);
    chk("t5_ivec", ivec, 16'o070);
    tick();
    chk("t5_virq_ack2", virq, 0);
    istb = 1'b0;
    tick();
    chk("t5_virq_hold", virq, 0);
    tick();
    chk("t5_virq_idle", virq, 0);
    tick();
    chk("t5_virq_back", virq, 1);
    istb = 1'b1;
    tick();
    chk("t5_ivec_again", ivec, 16'o070);
    istb = 1'b0; irq_req = '0;
    tick(); tick();

    // 4: reset asserted while in ACK
    irq_req = 8'b0000_0100;
    tick();
    istb = 1'b1;
    tick();
    chk("t4_iack_pre", iack, 1);
    rst = 1'b1;
    #1;
    chk("t4_iack_rst", iack, 0);
    chk("t4_ivec_rst", ivec, 0);
    chk("t4_virq_rst", virq, 0);
    chk("t4_dev_iack_rst", dev_iack, 0);
    istb = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("t4_virq_1cyc", virq, 0);
    tick();
    chk("t4_virq_2cyc", virq, 1);
    istb = 1'b1;
    tick();
    chk("t4_ivec_after", ivec, 16'o060);
    istb = 1'b0; irq_req = '0;
    tick(); tick();

    // 6: all requests held over 10 strobes
    do_reset();
    irq_req = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      istb = 1'b1;
      tick();
`ifdef IRQ_ROUNDROBIN_EN
      exp_oh = 8'b1 << (k % 8);
`else
      exp_oh = 8'b0000_0001;
`endif
      chk($sformatf("t6_dev_iack_%0d", k), dev_iack, exp_oh);
      istb = 1'b0;
      tick(); tick();
    end
    irq_req = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
